mem_bus_arbiter: RTL and testbench

Shares the single synchronous memory port between the CPU (primary requester) and one DMA-style secondary requester (video/IO). The CPU has fixed priority. The DMA requester takes idle CPU cycles (cycle stealing). If the DMA requester starves, the block forces a one-cycle CPU stall and serves DMA in that cycle. It sits between the CPU memory interface and the RAM; `cpuStall` gates the CPU clock-enable.

---
 rtl/mem_bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one synchronous memory port between the CPU (fixed priority) and a
// single DMA-style secondary requester. DMA accesses steal idle CPU cycles.
// When a DMA request has been denied STARVE_MAX consecutive cycles, the next
// cycle is a forced grant: the CPU is stalled for that one cycle and DMA
// owns the memory port.
//
// Parameters
//   M          data/address width
//   STARVE_MAX denied DMA cycles before a forced grant (1..2^CNT_W-1)
//   CNT_W      starvation counter width
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   cpuAddr/cpuWrite/cpuRE/cpuWE CPU memory request
//   cpuRead, cpuStall            CPU read data, CPU clock-enable gate
//   dmaReq/dmaWe/dmaAddr/dmaWData DMA request (held until dmaGnt)
//   dmaGnt, dmaAck, dmaRData     grant (same cycle), completion pulse, data
//   memAddr/memWData/memRE/memWE memory command, memRData read data
//                                (valid the cycle after memRE)
//
// Optional build macro ARB_STATS_EN adds stallCount and grantCount outputs
// (16-bit wrapping event counters). Without it arbitration is unchanged.
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int M          = 16,
  parameter int STARVE_MAX = 8,
  parameter int CNT_W      = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] cpuAddr,
  input  logic [M-1:0] cpuWrite,
  input  logic         cpuRE,
  input  logic         cpuWE,
  output logic [M-1:0] cpuRead,
  output logic         cpuStall,
  input  logic         dmaReq,
  input  logic         dmaWe,
  input  logic [M-1:0] dmaAddr,
  input  logic [M-1:0] dmaWData,
  output logic         dmaGnt,
  output logic         dmaAck,
  output logic [M-1:0] dmaRData,
  output logic [M-1:0] memAddr,
  output logic [M-1:0] memWData,
  output logic         memRE,
  output logic         memWE,
  input  logic [M-1:0] memRData
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]  stallCount,
  output logic [15:0]  grantCount
`endif
);

  typedef enum logic {OWNER_CPU = 1'b0, OWNER_DMA = 1'b1} owner_e;

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

  logic             cpu_idle;
  logic             force_grant;
  logic             cpu_rd_ret;
  logic             dma_rd_ret;

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  owner_e           rd_owner_q, rd_owner_d;
  logic             rd_pend_q, rd_pend_d;
  logic             dma_ack_q, dma_ack_d;
  logic             ack_is_read_q, ack_is_read_d;
  logic [M-1:0]     cpu_hold_q, cpu_hold_d;
  logic [M-1:0]     dma_rdata_q, dma_rdata_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign cpu_idle    = !cpuRE && !cpuWE;
  assign force_grant = (wait_cnt_q >= STARVE_LIM);
  assign dmaGnt      = dmaReq && (cpu_idle || force_grant);
  // A forced grant only costs the CPU a cycle if it actually wanted the port.
  assign cpuStall    = dmaReq && force_grant && !cpu_idle;

  always_comb begin
    memAddr  = cpuAddr;
    memWData = cpuWrite;
    memRE    = cpuRE && !cpuStall;
    memWE    = cpuWE && !cpuStall;
    if (dmaGnt) begin
      memAddr  = dmaAddr;
      memWData = dmaWData;
      memRE    = !dmaWe;
      memWE    = dmaWe;
    end
  end

  // ---------------------------------------------------------------------------
  // Read-data return: memory data arrives one cycle after memRE, and goes to
  // whichever side issued that read. Each side keeps a holding register so
  // its data stays stable while the other side uses the port.
  // ---------------------------------------------------------------------------
  assign cpu_rd_ret = rd_pend_q && (rd_owner_q == OWNER_CPU);
  assign dma_rd_ret = dma_ack_q && ack_is_read_q;

  assign cpuRead  = cpu_rd_ret ? memRData : cpu_hold_q;
  assign dmaRData = dma_rd_ret ? memRData : dma_rdata_q;
  assign dmaAck   = dma_ack_q;

  always_comb begin
    // Counter restarts whenever there is nothing waiting or the wait is over;
    // this also makes two forced grants in a row impossible.
    wait_cnt_d = wait_cnt_q;
    if (!dmaReq || dmaGnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != CNT_SAT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    rd_pend_d     = memRE;
    rd_owner_d    = dmaGnt ? OWNER_DMA : OWNER_CPU;
    dma_ack_d     = dmaGnt;
    ack_is_read_d = dmaGnt && !dmaWe;
    cpu_hold_d    = cpu_rd_ret ? memRData : cpu_hold_q;
    dma_rdata_d   = dma_rd_ret ? memRData : dma_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q    <= '0;
      rd_owner_q    <= OWNER_CPU;
      rd_pend_q     <= 1'b0;
      dma_ack_q     <= 1'b0;
      ack_is_read_q <= 1'b0;
      cpu_hold_q    <= '0;
      dma_rdata_q   <= '0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      rd_owner_q    <= rd_owner_d;
      rd_pend_q     <= rd_pend_d;
      dma_ack_q     <= dma_ack_d;
      ack_is_read_q <= ack_is_read_d;
      cpu_hold_q    <= cpu_hold_d;
      dma_rdata_q   <= dma_rdata_d;
    end
  end

`ifdef ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Event counters (wrap naturally at 16 bits).
  // ---------------------------------------------------------------------------
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] grant_cnt_q, grant_cnt_d;

  assign stall_cnt_d = stall_cnt_q + {15'd0, cpuStall};
  assign grant_cnt_d = grant_cnt_q + {15'd0, dmaGnt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      grant_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign stallCount = stall_cnt_q;
  assign grantCount = grant_cnt_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Self-checking bench for mem_bus_arbiter: reset values, a table of directed
// vectors (idle-cycle DMA writes/reads, starvation and forced stall, data
// stability across a stall), a reset-during-grant sequence, a continuous
// contention pattern, and a randomized run against a cycle-level reference
// model. A simple synchronous RAM sits on the memory port.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int M          = 16;
  localparam int STARVE_MAX = 8;

  logic         clk;
  logic         rst;
  logic [M-1:0] cpuAddr, cpuWrite, cpuRead;
  logic         cpuRE, cpuWE, cpuStall;
  logic         dmaReq, dmaWe, dmaGnt, dmaAck;
  logic [M-1:0] dmaAddr, dmaWData, dmaRData;
  logic [M-1:0] memAddr, memWData, memRData;
  logic         memRE, memWE;
`ifdef ARB_STATS_EN
  logic [15:0]  stallCount, grantCount;
`endif

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(.M(M), .STARVE_MAX(STARVE_MAX), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .cpuAddr(cpuAddr), .cpuWrite(cpuWrite), .cpuRE(cpuRE), .cpuWE(cpuWE),
    .cpuRead(cpuRead), .cpuStall(cpuStall),
    .dmaReq(dmaReq), .dmaWe(dmaWe), .dmaAddr(dmaAddr), .dmaWData(dmaWData),
    .dmaGnt(dmaGnt), .dmaAck(dmaAck), .dmaRData(dmaRData),
    .memAddr(memAddr), .memWData(memWData), .memRE(memRE), .memWE(memWE),
    .memRData(memRData)
`ifdef ARB_STATS_EN
    , .stallCount(stallCount), .grantCount(grantCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Background contents of never-written RAM locations.
  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // Environment RAM: registered read, one cycle latency.
  logic [15:0] ram_data [0:65535];
  logic        ram_wr   [0:65535];
  initial memRData = '0;
  always @(posedge clk) begin
    if (memRE) memRData <= ram_wr[memAddr] ? ram_data[memAddr] : init_val(memAddr);
    if (memWE) begin
      ram_data[memAddr] <= memWData;
      ram_wr[memAddr]   <= 1'b1;
    end
  end
  initial begin
    for (int i = 0; i < 65536; i++) ram_wr[i] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    cpuRE = 0; cpuWE = 0; cpuAddr = '0; cpuWrite = '0;
    dmaReq = 0; dmaWe = 0; dmaAddr = '0; dmaWData = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        re, we;
    logic [15:0] caddr;
    logic        req, dwe;
    logic [15:0] daddr, dwd;
    logic        gnt, stall, mre, mwe;
    logic [15:0] maddr;
    logic        ack;
    logic        chk_cr;
    logic [15:0] cr;
    logic        chk_dr;
    logic [15:0] dr;
  } vec_t;

  function automatic vec_t mkv(
    input logic re, input logic we, input logic [15:0] caddr,
    input logic req, input logic dwe, input logic [15:0] daddr, input logic [15:0] dwd,
    input logic gnt, input logic stall, input logic mre, input logic mwe,
    input logic [15:0] maddr, input logic ack,
    input logic chk_cr, input logic [15:0] cr, input logic chk_dr, input logic [15:0] dr);
    vec_t v;
    v.re = re; v.we = we; v.caddr = caddr;
    v.req = req; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
    v.gnt = gnt; v.stall = stall; v.mre = mre; v.mwe = mwe;
    v.maddr = maddr; v.ack = ack;
    v.chk_cr = chk_cr; v.cr = cr; v.chk_dr = chk_dr; v.dr = dr;
    return v;
  endfunction

  vec_t vecs [0:14];

  // ---------------------------------------------------------------------------
  // Reference model state for the randomized phase
  // ---------------------------------------------------------------------------
  logic [15:0] mdl_mem [int];
  int          m_denied;
  bit          m_cpu_rd_pend, m_ack, m_ack_rd;
  logic [15:0] m_cpu_rd_val, m_cpu_hold, m_dma_rd_val, m_dma_hold;
  int          m_stalls, m_grants;

  function automatic logic [15:0] mdl_rd(input logic [15:0] a);
    if (mdl_mem.exists(int'(a))) return mdl_mem[int'(a)];
    return init_val(a);
  endfunction

  task automatic model_reset();
    m_denied = 0; m_cpu_rd_pend = 0; m_ack = 0; m_ack_rd = 0;
    m_cpu_rd_val = '0; m_cpu_hold = '0; m_dma_rd_val = '0; m_dma_hold = '0;
    m_stalls = 0; m_grants = 0;
  endtask

  initial begin
    bit          prev_stall;
    bit          dma_out;
    bit          m_idle, m_force, m_gnt, m_stall, e_re, e_we;
    logic [15:0] e_addr, e_wd;
    int          r;

    rst = 1'b1;
    idle_inputs();

    // ---------------- reset state ----------------
    @(negedge clk); #1;
    chk("reset_cpuStall", cpuStall, 0);
    chk("reset_dmaGnt", dmaGnt, 0);
    chk("reset_memRE", memRE, 0);
    chk("reset_memWE", memWE, 0);
    chk("reset_cpuRead", cpuRead, 0);
    chk("reset_dmaAck", dmaAck, 0);
    chk("reset_dmaRData", dmaRData, 0);
`ifdef ARB_STATS_EN
    chk("reset_stallCount", stallCount, 0);
    chk("reset_grantCount", grantCount, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // ---------------- directed table ----------------
    //              re we caddr     req dwe daddr     dwd       gnt st mre mwe maddr    ack ccr cr        cdr dr
    vecs[0]  = mkv(0, 0, 16'h0000, 1, 1, 16'h1234, 16'hBEEF, 1, 0, 0, 1, 16'h1234, 0, 0, 16'h0000, 0, 16'h0000);
    vecs[1]  = mkv(0, 0, 16'h0000, 1, 1, 16'h0010, 16'hAAAA, 1, 0, 0, 1, 16'h0010, 1, 0, 16'h0000, 0, 16'h0000);
    vecs[2]  = mkv(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000);
    vecs[3]  = mkv(1, 0, 16'h0010, 1, 0, 16'h2000, 16'h0000, 0, 0, 1, 0, 16'h0010, 0, 1, 16'h0000, 0, 16'h0000);
    for (int i = 4; i <= 10; i++)
      vecs[i] = mkv(1, 0, 16'h0010, 1, 0, 16'h2000, 16'h0000, 0, 0, 1, 0, 16'h0010, 0, 1, 16'hAAAA, 0, 16'h0000);
    vecs[11] = mkv(1, 0, 16'h0010, 1, 0, 16'h2000, 16'h0000, 1, 1, 1, 0, 16'h2000, 0, 1, 16'hAAAA, 0, 16'h0000);
    vecs[12] = mkv(1, 0, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0010, 1, 1, 16'hAAAA, 1, 16'hE3A5);
    vecs[13] = mkv(0, 0, 16'h0000, 1, 0, 16'h1234, 16'h0000, 1, 0, 1, 0, 16'h1234, 0, 1, 16'hAAAA, 0, 16'h0000);
    vecs[14] = mkv(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'hBEEF);

    for (int i = 0; i <= 14; i++) begin
      @(negedge clk);
      cpuRE = vecs[i].re; cpuWE = vecs[i].we; cpuAddr = vecs[i].caddr; cpuWrite = '0;
      dmaReq = vecs[i].req; dmaWe = vecs[i].dwe; dmaAddr = vecs[i].daddr; dmaWData = vecs[i].dwd;
      #1;
      chk($sformatf("vec%0d_dmaGnt", i), dmaGnt, vecs[i].gnt);
      chk($sformatf("vec%0d_cpuStall", i), cpuStall, vecs[i].stall);
      chk($sformatf("vec%0d_memRE", i), memRE, vecs[i].mre);
      chk($sformatf("vec%0d_memWE", i), memWE, vecs[i].mwe);
      chk($sformatf("vec%0d_memAddr", i), memAddr, vecs[i].maddr);
      chk($sformatf("vec%0d_dmaAck", i), dmaAck, vecs[i].ack);
      if (vecs[i].chk_cr) chk($sformatf("vec%0d_cpuRead", i), cpuRead, vecs[i].cr);
      if (vecs[i].chk_dr) chk($sformatf("vec%0d_dmaRData", i), dmaRData, vecs[i].dr);
      $display("vec %0d: gnt=%0d stall=%0d memAddr=%04h ack=%0d cpuRead=%04h dmaRData=%04h",
               i, dmaGnt, cpuStall, memAddr, dmaAck, cpuRead, dmaRData);
    end

    // ---------------- reset during a grant ----------------
    apply_reset();
    @(negedge clk);
    idle_inputs(); cpuRE = 1; cpuAddr = 16'h0010;
    @(negedge clk);
    idle_inputs(); dmaReq = 1; dmaWe = 1; dmaAddr = 16'h3000; dmaWData = 16'h1111;
    #1;
    chk("rstseq_pre_gnt", dmaGnt, 1);
    chk("rstseq_pre_cpuRead", cpuRead, 16'hAAAA);
    rst = 1'b1;
    #1;
    chk("rstseq_cpuRead_dropped", cpuRead, 0);
    chk("rstseq_stall", cpuStall, 0);
    @(negedge clk); #1;
    chk("rstseq_ack_dropped", dmaAck, 0);
    chk("rstseq_dmaRData", dmaRData, 0);
    rst = 1'b0;
    #1;
    chk("rstseq_regrant", dmaGnt, 1);
    chk("rstseq_regrant_addr", memAddr, 16'h3000);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rstseq_regrant_ack", dmaAck, 1);
    $display("reset-during-grant sequence done");

    // ---------------- continuous contention ----------------
    apply_reset();
    prev_stall = 0;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      cpuRE = 1; cpuWE = 0; cpuAddr = 16'(i);
      dmaReq = 1; dmaWe = 0; dmaAddr = 16'h4000;
      #1;
      chk($sformatf("contend%0d_stall", i), cpuStall, (i % 9 == 8) ? 1 : 0);
      chk($sformatf("contend%0d_no_double", i), cpuStall & prev_stall, 0);
      prev_stall = cpuStall;
      $display("contend %0d: stall=%0d gnt=%0d", i, cpuStall, dmaGnt);
    end
    @(negedge clk);
    idle_inputs();
    #1;
`ifdef ARB_STATS_EN
    chk("contend_stallCount", stallCount, 3);
    chk("contend_grantCount", grantCount, 3);
`endif

    // ---------------- randomized vs reference model ----------------
    apply_reset();
    model_reset();
    dma_out = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r = $urandom_range(0, 9);
      if ((c / 150) % 2 == 1 && r < 3) r = 3;   // busy-CPU stretches provoke starvation
      cpuRE    = (r >= 3 && r < 7);
      cpuWE    = (r >= 7);
      cpuAddr  = 16'h0100 | 16'($urandom_range(0, 15));
      cpuWrite = 16'($urandom);
      if (!dma_out && $urandom_range(0, 2) != 0) begin
        dma_out  = 1;
        dmaWe    = 1'($urandom_range(0, 1));
        dmaAddr  = 16'h0100 | 16'($urandom_range(0, 15));
        dmaWData = 16'($urandom);
      end
      dmaReq = dma_out;
      #1;

      m_idle  = !cpuRE && !cpuWE;
      m_force = (m_denied >= STARVE_MAX);
      m_gnt   = dmaReq && (m_idle || m_force);
      m_stall = dmaReq && m_force && !m_idle;
      if (m_gnt) begin
        e_addr = dmaAddr; e_wd = dmaWData; e_we = dmaWe; e_re = !dmaWe;
      end else begin
        e_addr = cpuAddr; e_wd = cpuWrite; e_re = cpuRE && !m_stall; e_we = cpuWE && !m_stall;
      end

      chk("rnd_dmaGnt", dmaGnt, m_gnt);
      chk("rnd_cpuStall", cpuStall, m_stall);
      chk("rnd_memRE", memRE, e_re);
      chk("rnd_memWE", memWE, e_we);
      chk("rnd_memAddr", memAddr, e_addr);
      chk("rnd_memWData", memWData, e_wd);
      chk("rnd_dmaAck", dmaAck, m_ack);
      chk("rnd_dmaRData", dmaRData, m_ack_rd ? m_dma_rd_val : m_dma_hold);
      chk("rnd_cpuRead", cpuRead, m_cpu_rd_pend ? m_cpu_rd_val : m_cpu_hold);

      // advance the model by one clock
      if (m_cpu_rd_pend) m_cpu_hold = m_cpu_rd_val;
      if (m_ack_rd) m_dma_hold = m_dma_rd_val;
      m_cpu_rd_pend = e_re && !m_gnt;
      if (m_cpu_rd_pend) m_cpu_rd_val = mdl_rd(e_addr);
      m_ack    = m_gnt;
      m_ack_rd = m_gnt && !dmaWe;
      if (m_ack_rd) m_dma_rd_val = mdl_rd(e_addr);
      if (e_we) mdl_mem[int'(e_addr)] = e_wd;
      if (!dmaReq || m_gnt) m_denied = 0;
      else if (m_denied < 15) m_denied = m_denied + 1;
      m_stalls += int'(m_stall);
      m_grants += int'(m_gnt);
      if (m_gnt) dma_out = 0;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    $display("random run: %0d cycles, %0d stalls, %0d grants", 3000, m_stalls, m_grants);
`ifdef ARB_STATS_EN
    chk("rnd_stallCount", stallCount, 32'(m_stalls));
    chk("rnd_grantCount", grantCount, 32'(m_grants));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
